// File: rtl/acc_result_collector.sv
// acc_result_collector: receive side of the accumulator frame protocol. Checks acc_sel/acc_en
// framing, queues legal results in a small FIFO and presents them over valid/ready.
// Optional build macro ACC_COLLECT_RELU_EN clamps negative results to zero before queuing.
module acc_result_collector #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_sel,
  input  logic                     acc_en,
  input  logic [DATA_W-1:0]        acc_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     frame_err,
  output logic                     ovf,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int BEAT_W = $clog2(FRAME_LEN);

  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] FIRST_BEAT = BEAT_W'(1);
  localparam logic [FILL_W-1:0] FULL_FILL  = FILL_W'(DEPTH);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_IN_FRAME = 1'b1;

  logic [0:0]        r_state, w_state_next;
  logic [BEAT_W-1:0] r_beat, w_beat_next;
  logic              w_err, w_legal;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [FILL_W-1:0] r_fill, w_fill_after_pop, w_fill_next;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              w_pop, w_push, w_drop;
  logic [DATA_W-1:0] w_push_data;

  logic              r_frame_err, r_ovf;
  logic [CNT_W-1:0]  r_err_cnt, r_drop_cnt;

  // Frame tracker: beat 0 is the acc_sel cycle, acc_en is only legal on LAST_BEAT.
  always_comb begin
    w_state_next = r_state;
    w_beat_next  = r_beat;
    w_err        = 1'b0;
    w_legal      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (acc_sel) begin
          w_err        = acc_en;
          w_state_next = S_IN_FRAME;
          w_beat_next  = FIRST_BEAT;
        end else if (acc_en) begin
          w_err = 1'b1;
        end
      end
      default: begin
        if (acc_en) begin
          if (r_beat == LAST_BEAT) begin
            w_legal = 1'b1;
            if (acc_sel) begin
              w_beat_next = FIRST_BEAT;
            end else begin
              w_state_next = S_IDLE;
              w_beat_next  = '0;
            end
          end else begin
            w_err        = 1'b1;
            w_state_next = S_IDLE;
            w_beat_next  = '0;
          end
        end else if (acc_sel) begin
          w_err       = 1'b1;
          w_beat_next = FIRST_BEAT;
        end else if (r_beat == LAST_BEAT) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
          w_beat_next  = '0;
        end else begin
          w_beat_next = r_beat + 1'b1;
        end
      end
    endcase
  end

`ifdef ACC_COLLECT_RELU_EN
  assign w_push_data = acc_data[DATA_W-1] ? '0 : acc_data;
`else
  assign w_push_data = acc_data;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_pop            = r_out_valid & out_ready;
  assign w_push           = w_legal & ((r_fill != FULL_FILL) | w_pop);
  assign w_drop           = w_legal & (r_fill == FULL_FILL) & ~w_pop;
  assign w_rd_ptr_next    = r_rd_ptr + PTR_W'(w_pop);
  assign w_fill_after_pop = r_fill - FILL_W'(w_pop);
  assign w_fill_next      = w_fill_after_pop + FILL_W'(w_push);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_beat      <= w_beat_next;
      r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr    <= w_rd_ptr_next;
      r_fill      <= w_fill_next;
      r_out_valid <= (w_fill_next != '0);
      // The next head bypasses the RAM when the pushed word lands in an otherwise empty FIFO.
      if (w_fill_next != '0) begin
        r_out_data <= (w_fill_after_pop == '0) ? w_push_data : r_mem[w_rd_ptr_next];
      end
      r_frame_err <= w_err;
      r_ovf       <= w_drop;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign fill      = r_fill;
  assign frame_err = r_frame_err;
  assign ovf       = r_ovf;
  assign err_cnt   = r_err_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_acc_result_collector.sv
// Self-checking bench for acc_result_collector: constant vector table, directed corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_acc_result_collector;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 4;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 8;
  localparam int FILL_W    = $clog2(DEPTH) + 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              acc_sel = 1'b0;
  logic              acc_en = 1'b0;
  logic [DATA_W-1:0] acc_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [FILL_W-1:0] fill;
  logic              frame_err;
  logic              ovf;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  acc_result_collector #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .acc_sel(acc_sel), .acc_en(acc_en), .acc_data(acc_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fill(fill), .frame_err(frame_err), .ovf(ovf),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value expected at the output for a given accumulator result.
  function automatic logic [DATA_W-1:0] stored_value(input logic [DATA_W-1:0] v);
`ifdef ACC_COLLECT_RELU_EN
    if ($signed(v) < 0) return '0;
`endif
    return v;
  endfunction

  // ---------------- reference model ----------------
  bit                m_in_frame;
  int                m_since_sel;
  logic [DATA_W-1:0] m_q[$];
  int                m_err_cnt, m_drop_cnt;
  bit                m_err, m_ovf;

  task automatic model_reset();
    m_in_frame = 0; m_since_sel = 0; m_q.delete();
    m_err_cnt = 0; m_drop_cnt = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic step(input string tag, input bit sel, input bit en,
                      input logic [DATA_W-1:0] d, input bit rdy);
    bit legal;
    bit popped;
    logic [DATA_W-1:0] head;
    legal = 0;
    head = '0;
    acc_sel = sel; acc_en = en; acc_data = d; out_ready = rdy;
    popped = (m_q.size() != 0) && rdy;
    @(posedge clk); #1;
    m_err = 0; m_ovf = 0;
    if (!m_in_frame) begin
      if (sel) begin
        m_err = en; m_in_frame = 1; m_since_sel = 1;
      end else if (en) begin
        m_err = 1;
      end
    end else if (en) begin
      if (m_since_sel == FRAME_LEN - 1) begin
        legal = 1;
        if (sel) m_since_sel = 1;
        else m_in_frame = 0;
      end else begin
        m_err = 1; m_in_frame = 0;
      end
    end else if (sel) begin
      m_err = 1; m_since_sel = 1;
    end else if (m_since_sel == FRAME_LEN - 1) begin
      m_err = 1; m_in_frame = 0;
    end else begin
      m_since_sel++;
    end
    if (popped) head = m_q.pop_front();
    if (legal) begin
      if (m_q.size() < DEPTH) m_q.push_back(stored_value(d));
      else m_ovf = 1;
    end
    if (m_err && m_err_cnt < CNT_MAX) m_err_cnt++;
    if (m_ovf && m_drop_cnt < CNT_MAX) m_drop_cnt++;

    check($sformatf("%s valid", tag), 32'(out_valid), 32'(m_q.size() != 0));
    check($sformatf("%s fill", tag), 32'(fill), 32'(m_q.size()));
    check($sformatf("%s frame_err", tag), 32'(frame_err), 32'(m_err));
    check($sformatf("%s ovf", tag), 32'(ovf), 32'(m_ovf));
    check($sformatf("%s err_cnt", tag), 32'(err_cnt), 32'(m_err_cnt));
    check($sformatf("%s drop_cnt", tag), 32'(drop_cnt), 32'(m_drop_cnt));
    if (m_q.size() != 0) check($sformatf("%s data", tag), 32'(out_data), 32'(m_q[0]));
    if (popped) $display("%s: popped 0x%04h, fill now %0d", tag, head, fill);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; acc_sel = 0; acc_en = 0; out_ready = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit                sel;
    bit                en;
    logic [DATA_W-1:0] data;
    bit                rdy;
    bit                exp_valid;
    logic [DATA_W-1:0] exp_data;
    int                exp_fill;
    bit                exp_err;
    int                exp_err_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit sel, input bit en, input logic [DATA_W-1:0] d, input bit rdy,
                     input bit ev, input logic [DATA_W-1:0] ed, input int ef,
                     input bit ee, input int ec);
    vec_t v;
    v.sel = sel; v.en = en; v.data = d; v.rdy = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_fill = ef; v.exp_err = ee; v.exp_err_cnt = ec;
    vecs.push_back(v);
  endtask

  initial begin
    int ovf_seen;
    logic [DATA_W-1:0] order[4];
    bit sel_r, en_r;

    // Reset state while reset is held.
    @(negedge clk); @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset fill", 32'(fill), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
    check("reset drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 0;

    // sel  en  data     rdy  valid data  fill err errcnt
    add(1, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'h0123, 1,   1, 16'h0123, 1, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'hFF00, 0,   1, stored_value(16'hFF00), 1, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(1, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'hDEAD, 1,   0, 16'h0000, 0, 1, 1);
    add(0, 1, 16'hBEEF, 1,   0, 16'h0000, 0, 1, 2);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 2);
    add(1, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 2);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 2);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 2);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 1, 3);
    add(0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 3);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      acc_sel = vecs[i].sel; acc_en = vecs[i].en;
      acc_data = vecs[i].data; out_ready = vecs[i].rdy;
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d fill", i), 32'(fill), 32'(vecs[i].exp_fill));
      check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err_cnt));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'd0);
      $display("vec %0d: sel=%0d en=%0d data=0x%04h rdy=%0d -> valid=%0d out=0x%04h fill=%0d err=%0d",
               i, vecs[i].sel, vecs[i].en, vecs[i].data, vecs[i].rdy,
               out_valid, out_data, fill, frame_err);
    end

    // Five back-to-back frames into a stalled FIFO, then a push coinciding with a pop.
    do_reset();
    ovf_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step($sformatf("ovf f%0d sel", k), 1, 0, 16'h0, 0);
      for (int b = 1; b < FRAME_LEN - 1; b++) step($sformatf("ovf f%0d b%0d", k, b), 0, 0, 16'h0, 0);
      step($sformatf("ovf f%0d en", k), 0, 1, DATA_W'(16'h1000 + k), 0);
      if (ovf) ovf_seen++;
    end
    step("ovf idle", 0, 0, 16'h0, 0);
    if (ovf) ovf_seen++;
    check("ovf pulse count", 32'(ovf_seen), 32'd1);
    check("ovf fill full", 32'(fill), 32'd4);
    check("ovf drop_cnt", 32'(drop_cnt), 32'd1);
    step("fullpop sel", 1, 0, 16'h0, 0);
    for (int b = 1; b < FRAME_LEN - 1; b++) step($sformatf("fullpop b%0d", b), 0, 0, 16'h0, 0);
    step("fullpop en", 0, 1, 16'h1005, 1);
    check("fullpop ovf", 32'(ovf), 32'd0);
    check("fullpop fill", 32'(fill), 32'd4);
    order[0] = 16'h1001; order[1] = 16'h1002; order[2] = 16'h1003; order[3] = 16'h1005;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("order %0d", j), 32'(out_data), 32'(order[j]));
      step($sformatf("drain %0d", j), 0, 0, 16'h0, 1);
    end
    check("drained fill", 32'(fill), 32'd0);

    // Error counter saturation.
    do_reset();
    for (int k = 0; k < CNT_MAX + 5; k++) step($sformatf("sat %0d", k), 0, 1, 16'h0, 1);
    check("err_cnt saturated", 32'(err_cnt), 32'(CNT_MAX));

    // Asynchronous reset mid-frame with two results queued.
    do_reset();
    step("mr sel0", 1, 0, 16'h0, 0);
    step("mr b1", 0, 0, 16'h0, 0);
    step("mr bad en", 0, 1, 16'h0, 0);
    for (int k = 0; k < 2; k++) begin
      step($sformatf("mr f%0d sel", k), 1, 0, 16'h0, 0);
      for (int b = 1; b < FRAME_LEN - 1; b++) step($sformatf("mr f%0d b%0d", k, b), 0, 0, 16'h0, 0);
      step($sformatf("mr f%0d en", k), 0, 1, DATA_W'(16'h2000 + k), 0);
    end
    step("mr sel", 1, 0, 16'h0, 0);
    step("mr mid", 0, 0, 16'h0, 0);
    check("mr pre fill", 32'(fill), 32'd2);
    check("mr pre err_cnt", 32'(err_cnt), 32'd1);
    acc_sel = 0; acc_en = 0; out_ready = 0;
    #2 reset = 1;
    #1;
    check("mr async out_valid", 32'(out_valid), 32'd0);
    check("mr async fill", 32'(fill), 32'd0);
    check("mr async err_cnt", 32'(err_cnt), 32'd0);
    check("mr async drop_cnt", 32'(drop_cnt), 32'd0);
    check("mr async out_data", 32'(out_data), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    model_reset();
    step("post sel", 1, 0, 16'h0, 0);
    for (int b = 1; b < FRAME_LEN - 1; b++) step($sformatf("post b%0d", b), 0, 0, 16'h0, 0);
    step("post en", 0, 1, 16'h0456, 0);
    check("post valid", 32'(out_valid), 32'd1);
    check("post data", 32'(out_data), 32'h0456);
    step("post pop", 0, 0, 16'h0, 1);

    // Randomized traffic: mostly legal frames with occasional protocol abuse.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        step($sformatf("rnd%0d sel", n), 1, 0, DATA_W'($urandom), $urandom_range(0, 1) == 1);
        for (int b = 1; b < FRAME_LEN - 1; b++)
          step($sformatf("rnd%0d b%0d", n, b), 0, 0, DATA_W'($urandom), $urandom_range(0, 2) == 0);
        step($sformatf("rnd%0d en", n), $urandom_range(0, 3) == 0, 1, DATA_W'($urandom),
             $urandom_range(0, 1) == 1);
      end else begin
        for (int b = 0; b < $urandom_range(1, 3); b++) begin
          sel_r = $urandom_range(0, 2) == 0;
          en_r  = $urandom_range(0, 2) == 0;
          step($sformatf("rnd%0d junk%0d", n, b), sel_r, en_r, DATA_W'($urandom),
               $urandom_range(0, 1) == 1);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
